// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    END   = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

  // Pointer width for a power-of-two queue; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched {instr, pc} pairs with synchronous flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  fetch_entry_t                  push_entry_i,
  input  logic                          pop_i,
  output fetch_entry_t                  head_entry_o,
  output logic [ptr_width(DEPTH):0]     count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_entry_o = mem_q[head_q];

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush_i && do_push) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC sequencer feeding decode through a small fetch queue, with EX branch redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [63:0] IMEM_LIMIT  = 64'd40
) (
  input  logic         clk,
  input  logic         reset,
  output logic [63:0]  Instr_Addr,
  input  logic [31:0]  Instruction,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_instr,
  output logic [63:0]  out_pc,
  output logic         halted,
  output fetch_state_t dbg_state
);

  localparam int unsigned CW = ptr_width(QUEUE_DEPTH) + 1;

  logic [63:0]   pc_q, pc_d;
  fetch_state_t  state_q, state_d;

  fetch_entry_t  q_head;
  fetch_entry_t  q_push_entry;
  logic [CW-1:0] q_count;
  logic [CW-1:0] count_after;
  logic          q_full, q_empty;
  logic          deq, enq;
  logic [63:0]   redirect_aligned;

  // Decode handshake: out_valid/out_instr/out_pc are held stable until out_ready
  // is seen with out_valid; the head is consumed on that cycle (deq), even if a
  // redirect flushes the queue at the same edge.
  assign deq = out_valid && out_ready;

  assign redirect_aligned = redirect_pc & ~64'h3;
  assign q_push_entry     = '{instr: Instruction, pc: pc_q};

  assign enq = !redirect_valid && (state_q == FETCH) && (pc_q < IMEM_LIMIT)
               && (!q_full || deq);

  assign count_after = q_count + CW'(enq) - CW'(deq);

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_aligned;
      state_d = (redirect_aligned >= IMEM_LIMIT) ? END : FETCH;
    end else begin
      if (enq) pc_d = pc_q + 64'(INSTR_BYTES);
      if (pc_d >= IMEM_LIMIT) begin
        state_d = END;
      end else begin
        unique case (state_q)
          FETCH:   state_d = (count_after == CW'(QUEUE_DEPTH)) ? STALL : FETCH;
          STALL:   state_d = deq ? FETCH : STALL;
          END:     state_d = END;
          default: state_d = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect_valid),
    .push_i       (enq),
    .push_entry_i (q_push_entry),
    .pop_i        (deq),
    .head_entry_o (q_head),
    .count_o      (q_count),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

  assign Instr_Addr = pc_q;
  assign out_valid  = !q_empty;
  assign out_instr  = out_valid ? q_head.instr : NOP_INSTR;
  assign out_pc     = out_valid ? q_head.pc : 64'h0;
  assign halted     = (state_q == END) && (q_count == '0);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a 10-word program image.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         reset;
  logic [63:0]  Instr_Addr;
  logic [31:0]  Instruction;
  logic         redirect_valid;
  logic [63:0]  redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_instr;
  logic [63:0]  out_pc;
  logic         halted;
  fetch_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] prog [16] = '{
    32'h00e68633, 32'h00100513, 32'h00200593, 32'h00b50633,
    32'h00c12023, 32'h00012683, 32'h00d60733, 32'h00200793,
    32'h00f6c463, 32'h00000073, 32'h00000013, 32'h00000013,
    32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013
  };

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory
  always_comb begin
    Instruction = NOP_INSTR;
    if (Instr_Addr < 64'd40) Instruction = prog[Instr_Addr[5:2]];
  end

  instruction_fetch_unit #(
    .QUEUE_DEPTH (2),
    .RESET_PC    (64'h0),
    .IMEM_LIMIT  (64'd40)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .Instr_Addr     (Instr_Addr),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input logic ready);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = ready;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"},   Instr_Addr, 64'h0);
    chk({tag, "_valid"},  64'(out_valid), 64'h0);
    chk({tag, "_instr"},  64'(out_instr), 64'(NOP_INSTR));
    chk({tag, "_pc"},     out_pc, 64'h0);
    chk({tag, "_halted"}, 64'(halted), 64'h0);
    chk({tag, "_state"},  64'(dbg_state), 64'(FETCH));
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;

    // Streaming with decode always ready: one word per cycle from cycle 1.
    apply_reset(1'b1);
    chk_reset_state("rst");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stream_valid%0d", i), 64'(out_valid), 64'h1);
      chk($sformatf("stream_pc%0d", i), out_pc, 64'(4 * i));
      chk($sformatf("stream_instr%0d", i), 64'(out_instr), 64'(prog[i]));
    end
    @(negedge clk);
    chk("stream_halted", 64'(halted), 64'h1);
    chk("stream_valid_end", 64'(out_valid), 64'h0);
    chk("stream_instr_end", 64'(out_instr), 64'(NOP_INSTR));
    chk("stream_state_end", 64'(dbg_state), 64'(END));

    // Back-pressure from reset: queue fills, PC parks at 8.
    apply_reset(1'b0);
    @(negedge clk);
    chk("bp_valid1", 64'(out_valid), 64'h1);
    chk("bp_pc1", out_pc, 64'h0);
    @(negedge clk);
    chk("bp_state2", 64'(dbg_state), 64'(STALL));
    chk("bp_addr2", Instr_Addr, 64'h8);
    chk("bp_pc2", out_pc, 64'h0);
    @(negedge clk);
    chk("bp_hold_pc", out_pc, 64'h0);
    chk("bp_hold_instr", 64'(out_instr), 64'h00e68633);
    chk("bp_hold_addr", Instr_Addr, 64'h8);
    chk("bp_hold_state", 64'(dbg_state), 64'(STALL));
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_pc4", out_pc, 64'h4);
    chk("bp_rel_state", 64'(dbg_state), 64'(FETCH));
    @(negedge clk);
    chk("bp_rel_valid8", 64'(out_valid), 64'h1);
    chk("bp_rel_pc8", out_pc, 64'h8);

    // Redirect to 32 in cycle 3 with the queue holding pc 8.
    apply_reset(1'b1);
    @(negedge clk);
    chk("rd_pc0", out_pc, 64'h0);
    @(negedge clk);
    chk("rd_pc4", out_pc, 64'h4);
    @(negedge clk);
    chk("rd_pc8", out_pc, 64'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 64'd32;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd_bubble_valid", 64'(out_valid), 64'h0);
    chk("rd_bubble_addr", Instr_Addr, 64'd32);
    @(negedge clk);
    chk("rd_tgt_valid", 64'(out_valid), 64'h1);
    chk("rd_tgt_pc", out_pc, 64'd32);
    chk("rd_tgt_instr", 64'(out_instr), 64'h00f6c463);
    @(negedge clk);
    chk("rd_next_pc", out_pc, 64'd36);

    // Misaligned target 0x1F lands on 0x1C.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1F;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mis_bubble_valid", 64'(out_valid), 64'h0);
    chk("mis_addr", Instr_Addr, 64'd28);
    @(negedge clk);
    chk("mis_pc", out_pc, 64'd28);
    chk("mis_instr", 64'(out_instr), 64'h00200793);
    @(negedge clk);
    chk("mis_next_pc", out_pc, 64'd32);

    // Redirect beyond the program halts; a redirect to 0 resumes.
    redirect_valid = 1'b1;
    redirect_pc    = 64'd48;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("oob_valid", 64'(out_valid), 64'h0);
    chk("oob_halted", 64'(halted), 64'h1);
    chk("oob_addr", Instr_Addr, 64'd48);
    @(negedge clk);
    chk("oob_valid2", 64'(out_valid), 64'h0);
    chk("oob_halted2", 64'(halted), 64'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("resume_halted", 64'(halted), 64'h0);
    chk("resume_addr", Instr_Addr, 64'h0);
    chk("resume_valid0", 64'(out_valid), 64'h0);
    @(negedge clk);
    chk("resume_valid", 64'(out_valid), 64'h1);
    chk("resume_pc", out_pc, 64'h0);
    chk("resume_instr", 64'(out_instr), 64'h00e68633);

    // Reset with a full queue and a coincident redirect.
    apply_reset(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rr_full_state", 64'(dbg_state), 64'(STALL));
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'd32;
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    chk_reset_state("rr");
    out_ready = 1'b1;
    @(negedge clk);
    chk("rr_restart_valid", 64'(out_valid), 64'h1);
    chk("rr_restart_pc0", out_pc, 64'h0);
    @(negedge clk);
    chk("rr_restart_pc4", out_pc, 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequencer that owns the program counter and drives the byte-addressed instruction memory (64-bit `Instr_Addr` in, 32-bit `Instruction` out, combinational read). Each cycle it fetches one word at the PC into a small in-order fetch queue and presents queued instructions to decode over a valid/ready handshake. It absorbs decode back-pressure and applies branch redirects from EX, flushing wrong-path words. It sits between the PC/IF stage and the IF/ID pipeline register of the pipelined processor.

## Interface
- `QUEUE_DEPTH`, 2, fetch-queue entries; power of two, at least 2
- `RESET_PC`, 64'h0, PC loaded on reset
- `IMEM_LIMIT`, 64'd40, first byte address past the loaded program; fetch stops when PC >= this
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `Instr_Addr` out 64: byte address to instruction memory, always equals the PC register
- `Instruction` in 32: memory read data for `Instr_Addr`, valid in the same cycle
- `redirect_valid` in 1: branch/jump taken in EX; single-cycle pulse
- `redirect_pc` in 64: target byte address, sampled when `redirect_valid`=1
- `out_valid` out 1: head queue entry valid
- `out_ready` in 1: decode accepts head entry
- `out_instr` out 32: head instruction; 32'h00000013 (NOP) when `out_valid`=0
- `out_pc` out 64: byte address of `out_instr`
- `halted` out 1: PC >= `IMEM_LIMIT` and queue empty

## Operation
- FSM states: FETCH, STALL, END.
  - FETCH: enqueue when the queue has space or a dequeue occurs this cycle.
  - STALL: queue full and no dequeue; PC held; no enqueue.
  - END: PC >= `IMEM_LIMIT`; no enqueue; queue keeps draining.
- Enqueue: push {`Instruction`, PC}; PC <= PC + 4. PC arithmetic is 64-bit unsigned and wraps at 2^64.
- Dequeue: occurs when `out_valid` and `out_ready` are both 1 in the same cycle.
- Simultaneous enqueue and dequeue on a full queue is legal; the count is unchanged.
- Next-state rules:
  - Any state moves to END when the next PC >= `IMEM_LIMIT`.
  - FETCH moves to STALL when the count after the update equals `QUEUE_DEPTH`.
  - STALL returns to FETCH once a dequeue occurs.
- Redirect has highest priority. In that cycle:
  - Queue is flushed (count <= 0); no enqueue.
  - A dequeue handshake in the same cycle still counts as consumed.
  - PC <= {`redirect_pc`[63:2], 2'b00}; misaligned targets are force-aligned.
  - Next state is FETCH, or END if the target >= `IMEM_LIMIT`.
- `halted` is combinational: state END and count = 0.

## Timing
- Reset values: PC = `RESET_PC`, `Instr_Addr` = `RESET_PC`, count = 0, state FETCH, `out_valid` = 0, `out_instr` = NOP, `out_pc` = 0, `halted` = 0. Reset mid-operation discards queue contents and any same-cycle redirect.
- Fetch-to-decode latency is 1 cycle. The word at PC is enqueued at edge N, and `out_valid` = 1 in cycle N+1.
- Throughput is 1 instruction per cycle when `out_ready` is held at 1.
- Redirect bubble: redirect in cycle N, target fetched in cycle N+1, target visible at decode in cycle N+2. `out_valid` = 0 in cycle N+1.
- `out_*` must not change while `out_valid`=1 and `out_ready`=0, except when a redirect flushes the queue.
- `Instr_Addr` changes only at the clock edge.

## Structure
- Package `fetch_pkg`:
  - State enum: FETCH, STALL, END.
  - `INSTR_BYTES` = 4.
  - `NOP_INSTR` = 32'h00000013.
- Sub-module `fetch_queue`: circular FIFO of {instr, pc} with head/tail pointers sized by `$clog2(QUEUE_DEPTH)` that wrap modulo depth, plus a count, a synchronous flush, and push/pop.
- The top-level module contains the PC register, the FSM and the redirect logic.

## Test plan
- Reset, then `out_ready`=1 over a 10-word program (limit 40):
  - `out_pc` steps 0, 4, … 36 on consecutive cycles starting from cycle 1.
  - `out_instr`[0] = 32'h00e68633.
  - `halted` = 1 after the word at pc 36 is consumed.
- `out_ready`=0 from reset:
  - Queue fills to 2 (words at 0 and 4); `Instr_Addr` holds 8; state STALL.
  - Raising `out_ready` then yields pc 0, 4, 8 back to back.
- Redirect to 32 in cycle 3 with the queue non-empty:
  - Next cycle `out_valid`=0 and `Instr_Addr`=32.
  - The following cycle `out_pc`=32, `out_instr`=32'h00f6c463.
  - No wrong-path pc reaches decode.
- Redirect to 0x1F: aligned to 0x1C, so `out_pc`=28 and `out_instr`=32'h00200793.
- Redirect to 48 (>= limit): `out_valid` stays 0 and `halted`=1 one cycle later. A further redirect to 0 resumes fetch.
- Reset asserted while the queue is full and a redirect fires in the same cycle:
  - All outputs return to reset values next cycle; the redirect is ignored.
  - Fetching restarts at `RESET_PC`.
